// File: rtl/ws2812_frame_scheduler_if.sv
// Pixel stream between the frame scheduler (master) and the WS2812 bit encoder (slave).
// enc_idle travels with the stream because the scheduler needs it to time the latch gap.
interface ws2812_frame_scheduler_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        enc_idle;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready,
        input  enc_idle
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        output enc_idle
    );
endinterface

// File: rtl/ws2812_frame_scheduler.sv
// WS2812 frame scheduler: GRB pixel buffer, in-order pixel streaming, latch gap and frame_done.
// Optional macro WS2812_AUTO_REFRESH_EN adds a free-running internal start request at REFRESH_HZ.
module ws2812_frame_scheduler #(
    parameter  int LED_NUM    = 8,
    parameter  int CLK_FRE    = 50_000_000,
    parameter  int RESET_US   = 80,
    parameter  int REFRESH_HZ = 30,
    localparam int AW         = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [23:0]              i_wr_data,
    input  logic                     i_frame_start,
    ws2812_frame_scheduler_if.master pix_if,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    localparam int              RESET_CYCLES   = (CLK_FRE / 1_000_000) * RESET_US;
    localparam int              REFRESH_CYCLES = CLK_FRE / REFRESH_HZ;
    localparam int              CW             = $clog2(RESET_CYCLES);
    localparam logic [AW:0]     LED_CNT        = (AW+1)'(LED_NUM);
    localparam logic [AW-1:0]   LAST_IDX       = AW'(LED_NUM - 1);
    localparam logic [CW-1:0]   LATCH_LAST     = CW'(RESET_CYCLES - 1);

    if (LED_NUM < 1 || LED_NUM > 512 || RESET_US <= 50 || RESET_CYCLES < 2 || REFRESH_CYCLES < 2) begin : g_paramCheck
        $error("ws2812_frame_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DRAIN,
        S_LATCH
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [AW-1:0]   r_index;
    logic            r_pending;
    logic [CW-1:0]   r_latchCnt;
    logic [23:0]     r_pixData;
    logic [23:0]     r_mem [LED_NUM];
    logic            w_start;
    logic            w_lastCount;

`ifdef WS2812_AUTO_REFRESH_EN
    localparam int            RW           = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] r_refreshCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refreshCnt <= '0;
        end else if (r_refreshCnt == REFRESH_LAST) begin
            r_refreshCnt <= '0;
        end else begin
            r_refreshCnt <= r_refreshCnt + 1'b1;
        end
    end

    assign w_start = i_frame_start | (r_refreshCnt == REFRESH_LAST);
`else
    assign w_start = i_frame_start;
`endif

    // Buffer is plain RAM: no reset, writes accepted in every state.
    always_ff @(posedge clk) begin
        if (i_wr_en && ({1'b0, i_wr_addr} < LED_CNT)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign w_lastCount = (r_latchCnt == LATCH_LAST);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_start || r_pending) w_nextState = S_FETCH;
            S_FETCH: w_nextState = S_SEND;
            S_SEND: begin
                if (pix_if.pix_ready) begin
                    w_nextState = (r_index == LAST_IDX) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: if (pix_if.enc_idle) w_nextState = S_LATCH;
            S_LATCH: if (w_lastCount) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Requests arriving while busy (including the frame_done cycle) collapse into one pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index    <= '0;
            r_pending  <= 1'b0;
            r_latchCnt <= '0;
            r_pixData  <= '0;
        end else begin
            if (r_state != S_IDLE && w_start) begin
                r_pending <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                S_IDLE:  r_index <= '0;
                S_FETCH: r_pixData <= r_mem[r_index];
                S_SEND: begin
                    if (pix_if.pix_ready && r_index != LAST_IDX) begin
                        r_index <= r_index + 1'b1;
                    end
                end
                S_DRAIN: r_latchCnt <= '0;
                S_LATCH: r_latchCnt <= w_lastCount ? '0 : r_latchCnt + 1'b1;
                default: r_index <= '0;
            endcase
        end
    end

    assign pix_if.pix_valid = (r_state == S_SEND);
    assign pix_if.pix_data  = r_pixData;
    assign o_busy           = (r_state != S_IDLE);
    assign o_frame_done     = (r_state == S_LATCH) && w_lastCount;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed bench for ws2812_frame_scheduler: LED_NUM=3, 50 MHz, 80 us latch (4000 cycles).
// The bench plays the encoder role on the pixel stream interface.
module tb_ws2812_frame_scheduler;

    localparam int AW = 2;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          wrEn       = 1'b0;
    logic [AW-1:0] wrAddr     = '0;
    logic [23:0]   wrData     = '0;
    logic          frameStart = 1'b0;
    logic          busy;
    logic          frameDone;
    int            vectors     = 0;
    int            miscompares = 0;

    ws2812_frame_scheduler_if pixIf ();

    ws2812_frame_scheduler #(
        .LED_NUM   (3),
        .CLK_FRE   (50_000_000),
        .RESET_US  (80),
        .REFRESH_HZ(30)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (wrEn),
        .i_wr_addr    (wrAddr),
        .i_wr_data    (wrData),
        .i_frame_start(frameStart),
        .pix_if       (pixIf),
        .o_busy       (busy),
        .o_frame_done (frameDone)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [23:0] data, input logic start);
        wrEn       = we;
        wrAddr     = addr;
        wrData     = data;
        frameStart = start;
        tick();
        wrEn       = 1'b0;
        frameStart = 1'b0;
    endtask

    // Encoder model for one frame: ready after a delay per pixel, enc_idle 1200 cycles after the last handshake.
    task automatic serveFrame(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2,
                              input int stall0, input int startPix, input bit latchPulse,
                              input bit midWrite, input bit expectNext);
        logic [23:0] expPix [3];
        int n;
        int delay;
        expPix[0] = e0;
        expPix[1] = e1;
        expPix[2] = e2;
        pixIf.enc_idle = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            while (pixIf.pix_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checkOutput($sformatf("pixValid%0d", p), 32'(pixIf.pix_valid), 32'd1);
            checkOutput($sformatf("pixData%0d", p), 32'(pixIf.pix_data), 32'(expPix[p]));
            delay = (p == 0) ? stall0 : 3;
            for (int k = 0; k < delay; k++) begin
                frameStart = (p == startPix) && (k == 0);
                if (midWrite && p == 0 && k == 0) begin
                    wrEn = 1'b1; wrAddr = 2'd2; wrData = 24'h123456;
                end else if (midWrite && p == 0 && k == 1) begin
                    wrEn = 1'b1; wrAddr = 2'd3; wrData = 24'hABCDEF;
                end
                tick();
                frameStart = 1'b0;
                wrEn       = 1'b0;
                checkOutput($sformatf("holdValid%0d", p), 32'(pixIf.pix_valid), 32'd1);
                checkOutput($sformatf("holdData%0d", p), 32'(pixIf.pix_data), 32'(expPix[p]));
            end
            pixIf.pix_ready = 1'b1;
            tick();
            pixIf.pix_ready = 1'b0;
            checkOutput($sformatf("validDrop%0d", p), 32'(pixIf.pix_valid), 32'd0);
        end
        repeat (1200) tick();
        checkOutput("drainBusy", 32'(busy), 32'd1);
        checkOutput("drainNoDone", 32'(frameDone), 32'd0);
        pixIf.enc_idle = 1'b1;
        n = 0;
        while (frameDone !== 1'b1 && n < 4100) begin
            frameStart = latchPulse && (n == 100);
            tick();
            frameStart = 1'b0;
            n++;
        end
        checkOutput("latchCycles", 32'(n), 32'd4000);
        checkOutput("doneBusy", 32'(busy), 32'd1);
        tick();
        checkOutput("donePulse", 32'(frameDone), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        tick();
        checkOutput("nextFrame", 32'(busy), 32'(expectNext));
    endtask

    initial begin
        logic activity;
        int   n;
        pixIf.pix_ready = 1'b0;
        pixIf.enc_idle  = 1'b1;

        repeat (5) tick();
        checkOutput("rstValid", 32'(pixIf.pix_valid), 32'd0);
        checkOutput("rstData", 32'(pixIf.pix_data), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(frameDone), 32'd0);
        rst_n = 1'b1;
        activity = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            activity = activity | busy | pixIf.pix_valid | frameDone;
        end
        checkOutput("idleQuiet", 32'(activity), 32'd0);

        $display("[TB] basic frame");
        applyStimulus(1'b1, 2'd0, 24'h0000FF, 1'b0);
        applyStimulus(1'b1, 2'd1, 24'h00FF00, 1'b0);
        applyStimulus(1'b1, 2'd2, 24'hFF0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 24'h000000, 1'b1);
        checkOutput("startBusy", 32'(busy), 32'd1);
        serveFrame(24'h0000FF, 24'h00FF00, 24'hFF0000, 3, -1, 1'b0, 1'b0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 2'd0, 24'h000000, 1'b1);
        serveFrame(24'h0000FF, 24'h00FF00, 24'hFF0000, 50, -1, 1'b0, 1'b0, 1'b0);

        $display("[TB] pending request");
        applyStimulus(1'b0, 2'd0, 24'h000000, 1'b1);
        serveFrame(24'h0000FF, 24'h00FF00, 24'hFF0000, 3, 1, 1'b1, 1'b0, 1'b1);
        serveFrame(24'h0000FF, 24'h00FF00, 24'hFF0000, 3, -1, 1'b0, 1'b0, 1'b0);

        $display("[TB] write during frame");
        applyStimulus(1'b0, 2'd0, 24'h000000, 1'b1);
        serveFrame(24'h0000FF, 24'h00FF00, 24'h123456, 3, -1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 24'h000000, 1'b1);
        serveFrame(24'h0000FF, 24'h00FF00, 24'h123456, 3, -1, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 2'd0, 24'h000000, 1'b1);
        n = 0;
        while (pixIf.pix_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("preResetValid", 32'(pixIf.pix_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstValid", 32'(pixIf.pix_valid), 32'd0);
        checkOutput("asyncRstBusy", 32'(busy), 32'd0);
        checkOutput("asyncRstData", 32'(pixIf.pix_data), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        checkOutput("postRstValid", 32'(pixIf.pix_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
